// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: lock-state encoding and
// a constant clog2 used to size the round-robin pointer and lock owner.
package bram_arb_pkg;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_t;

  // Index width for value entries, never less than 1 bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage : bram_arb_pkg

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: rotates the request vector so the
// pointer position is bit 0, priority-encodes, and rotates the index back.
module rr_priority_select
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // i_ptr is always below NUM_REQ, so the window stays inside the doubled vector.
  assign w_req_dbl = {i_req, i_req};
  assign w_rot     = w_req_dbl[i_ptr +: NUM_REQ];

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin : select
    logic found;
    int   idx_sum;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    idx_sum = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_rot[k] && !found) begin
        found   = 1'b1;
        idx_sum = int'(i_ptr) + k;
        if (idx_sum >= NUM_REQ) idx_sum = idx_sum - NUM_REQ;
        o_idx   = PTR_W'(idx_sum);
      end
    end
    if (found) o_grant[o_idx] = 1'b1;
  end

endmodule : rr_priority_select

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with lock
// for bursts. Define BRAM_ARB_FIXED_PRIORITY0_EN to give requester 0 fixed priority.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writeData,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_readData,
  output logic                          bram_readEnable,
  output logic                          bram_writeEnable,
  output logic [ADDR_WIDTH-1:0]         bram_address,
  output logic [DATA_WIDTH-1:0]         bram_writeData,
  input  logic [DATA_WIDTH-1:0]         bram_readData
);

  localparam int PTR_W = clog2(NUM_REQ);

  arb_state_t            r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_lock_owner;
  logic [NUM_REQ-1:0]    r_resp_valid;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_wdata_hold;

  logic [NUM_REQ-1:0]    w_rr_grant;
  logic [PTR_W-1:0]      w_rr_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic [PTR_W-1:0]      w_next_ptr;
  logic                  w_accept;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_addr_arr[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[i] = req_writeData[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

  // Grant is forced low during reset so ready and both enables drop asynchronously.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    if (!reset) begin
      w_grant     = '0;
    end else if (r_state == ARB_LOCKED) begin
      if (req_valid[r_lock_owner]) begin
        w_grant[r_lock_owner] = 1'b1;
        w_grant_idx           = r_lock_owner;
      end
`ifdef BRAM_ARB_FIXED_PRIORITY0_EN
    end else if (req_valid[0]) begin
      w_grant[0]  = 1'b1;
      w_grant_idx = '0;
`endif
    end else begin
      w_grant     = w_rr_grant;
      w_grant_idx = w_rr_idx;
    end
  end

  always_comb begin
    if (int'(w_grant_idx) == NUM_REQ - 1) w_next_ptr = '0;
    else                                  w_next_ptr = w_grant_idx + PTR_W'(1);
`ifdef BRAM_ARB_FIXED_PRIORITY0_EN
    // Requester 0 sits outside the rotation, so serving it leaves the pointer alone.
    if (w_grant_idx == '0) w_next_ptr = r_rr_ptr;
`endif
  end

  assign w_accept = |w_grant;
  assign w_write  = req_write[w_grant_idx];

  assign req_ready        = w_grant;
  assign bram_readEnable  = w_accept & ~w_write;
  assign bram_writeEnable = w_accept &  w_write;
  assign bram_address     = w_accept ? w_addr_arr[w_grant_idx]  : r_addr_hold;
  assign bram_writeData   = w_accept ? w_wdata_arr[w_grant_idx] : r_wdata_hold;
  assign resp_valid       = r_resp_valid;
  assign resp_readData    = bram_readData;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_UNLOCKED;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      r_resp_valid <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_resp_valid <= (w_accept && !w_write) ? w_grant : '0;
      if (w_accept) begin
        r_addr_hold  <= w_addr_arr[w_grant_idx];
        r_wdata_hold <= w_wdata_arr[w_grant_idx];
      end
      case (r_state)
        ARB_UNLOCKED: begin
          if (w_accept) begin
            r_rr_ptr <= w_next_ptr;
            if (req_lock[w_grant_idx]) begin
              r_state      <= ARB_LOCKED;
              r_lock_owner <= w_grant_idx;
            end
          end
        end
        ARB_LOCKED: begin
          // Dropping the lock ends the burst; a beat accepted now is the last one.
          if (!req_lock[r_lock_owner]) begin
            r_state <= ARB_UNLOCKED;
            if (w_accept) r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ARB_UNLOCKED;
      endcase
    end
  end

endmodule : bram_port_arbiter

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus random
// traffic, compared every cycle against a cycle-level behavioural model.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [N-1:0]      req_lock;
  logic [N*AW-1:0]   req_address;
  logic [N*DW-1:0]   req_writeData;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_readData;
  logic              bram_readEnable;
  logic              bram_writeEnable;
  logic [AW-1:0]     bram_address;
  logic [DW-1:0]     bram_writeData;
  logic [DW-1:0]     bram_readData;

  int n_checks;
  int n_errors;

  bram_port_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_lock         (req_lock),
    .req_address      (req_address),
    .req_writeData    (req_writeData),
    .resp_valid       (resp_valid),
    .resp_readData    (resp_readData),
    .bram_readEnable  (bram_readEnable),
    .bram_writeEnable (bram_writeEnable),
    .bram_address     (bram_address),
    .bram_writeData   (bram_writeData),
    .bram_readData    (bram_readData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in BRAM with 1-cycle read latency.
  logic [DW-1:0] bram_mem [256];
  always @(posedge clock) begin
    if (bram_writeEnable) bram_mem[bram_address] <= bram_writeData;
    if (bram_readEnable)  bram_readData <= bram_mem[bram_address];
  end

  // Behavioural reference model state.
  logic [DW-1:0] m_mem [256];
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  logic [N-1:0]  m_resp_valid;
  logic [DW-1:0] m_resp_data;
  bit            m_have_last;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;

  function automatic logic [DW-1:0] init_word(int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic m_reset();
    m_ptr        = 0;
    m_locked     = 1'b0;
    m_owner      = 0;
    m_resp_valid = '0;
    m_resp_data  = '0;
    m_have_last  = 1'b0;
  endtask

  function automatic int model_grant(logic [N-1:0] v);
    int idx;
    if (m_locked) return v[m_owner] ? m_owner : -1;
`ifdef BRAM_ARB_FIXED_PRIORITY0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]                = v;
    req_write[i]                = w;
    req_lock[i]                 = l;
    req_address[i*AW +: AW]     = a;
    req_writeData[i*DW +: DW]   = d;
  endtask

  task automatic clear_all();
    req_valid     = '0;
    req_write     = '0;
    req_lock      = '0;
    req_address   = '0;
    req_writeData = '0;
  endtask

  // One clock: compare all outputs mid-cycle, advance the model, step past the edge.
  task automatic cycle();
    int            g;
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clock);
    g  = model_grant(req_valid);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    check("read_enable",  32'(bram_readEnable),  32'((g >= 0) && !req_write[g]));
    check("write_enable", 32'(bram_writeEnable), 32'((g >= 0) &&  req_write[g]));
    if (g >= 0) begin
      a = req_address[g*AW +: AW];
      d = req_writeData[g*DW +: DW];
      check("bram_address",   32'(bram_address), 32'(a));
      check("bram_writeData", bram_writeData, d);
    end else if (m_have_last) begin
      check("address_hold", 32'(bram_address), 32'(m_last_addr));
      check("wdata_hold",   bram_writeData,     m_last_wdata);
    end
    check("resp_valid", 32'(resp_valid), 32'(m_resp_valid));
    if (|m_resp_valid) check("resp_readData", resp_readData, m_resp_data);

    m_resp_valid = '0;
    if (g >= 0) begin
      m_have_last  = 1'b1;
      m_last_addr  = a;
      m_last_wdata = d;
      if (req_write[g]) m_mem[a] = d;
      else begin
        m_resp_valid[g] = 1'b1;
        m_resp_data     = m_mem[a];
      end
    end
    if (!m_locked) begin
      if (g >= 0) begin
`ifdef BRAM_ARB_FIXED_PRIORITY0_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
        if (req_lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end
    end else if (!req_lock[m_owner]) begin
      m_locked = 1'b0;
      if (g >= 0) begin
`ifdef BRAM_ARB_FIXED_PRIORITY0_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int a = 0; a < 256; a++) begin
      bram_mem[a] = init_word(a);
      m_mem[a]    = init_word(a);
    end
    bram_readData = '0;
    m_reset();
    clear_all();
    reset = 1'b0;

    // Reset: outputs quiet even with every requester asking.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready",  32'(req_ready),        32'h0);
    check("reset_resp",   32'(resp_valid),       32'h0);
    check("reset_rd_en",  32'(bram_readEnable),  32'h0);
    check("reset_wr_en",  32'(bram_writeEnable), 32'h0);
    reset = 1'b1;

    // Fairness: continuous reads from all four rotate 0,1,2,3.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(8'h10 + i), 32'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_order", 32'(req_ready), 32'(1 << (k % N)));
      cycle();
    end
    clear_all();
    cycle();

    // Write then read the same word from another requester.
    set_req(2, 1'b1, 1'b1, 1'b0, 8'h40, 32'hDEADBEEF);
    cycle();
    clear_all();
    set_req(1, 1'b1, 1'b0, 1'b0, 8'h40, 32'h0);
    cycle();
    clear_all();
    check("wr_rd_valid", 32'(resp_valid), 32'h2);
    check("wr_rd_data",  resp_readData,   32'hDEADBEEF);
    cycle();

    // Lock: requester 3 takes four beats while 0..2 wait, then 0 is next.
    set_req(3, 1'b1, 1'b0, 1'b1, 8'h20, 32'h0);
    for (int b = 0; b < 4; b++) begin
      if (b == 1) for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(8'h30 + i), 32'h0);
      if (b == 3) req_lock[3] = 1'b0;
      #1;
      check("lock_beat", 32'(req_ready), 32'h8);
      cycle();
    end
    req_valid[3] = 1'b0;
    #1;
    check("lock_after", 32'(req_ready), 32'h1);
    cycle();
    clear_all();
    cycle();

    // Lock with a valid gap: nobody is served while the holder is idle.
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h50, 32'h0);
    cycle();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h51, 32'h0);
    set_req(2, 1'b1, 1'b0, 1'b0, 8'h52, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 8'h53, 32'h0);
    req_valid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("lock_gap", 32'(req_ready), 32'h0);
      cycle();
    end
    req_valid[1] = 1'b1;
    #1;
    check("lock_resume", 32'(req_ready), 32'h2);
    cycle();
    req_lock[1] = 1'b0;
    cycle();
    req_valid[1] = 1'b0;
    #1;
    check("lock_release", 32'(req_ready), 32'h4);
    cycle();
    clear_all();
    cycle();

    // Random traffic with occasional locks over a small address window.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, AW'(8'h80 + $urandom_range(0, 7)), $urandom);
      cycle();
    end
    clear_all();
    repeat (2) cycle();

    // Reset mid-operation with a read response in flight.
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h11, 32'h0);
    cycle();
    check("pre_reset_resp", 32'(resp_valid), 32'(m_resp_valid));
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(8'h60 + i), 32'h0);
    reset = 1'b0;
    #1;
    check("midrst_resp",  32'(resp_valid),       32'h0);
    check("midrst_ready", 32'(req_ready),        32'h0);
    check("midrst_rd_en", 32'(bram_readEnable),  32'h0);
    check("midrst_wr_en", 32'(bram_writeEnable), 32'h0);
    m_reset();
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    clear_all();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("no_stale_resp", 32'(resp_valid), 32'h0);
      cycle();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(8'h60 + i), 32'h0);
    #1;
    check("post_reset_ptr", 32'(req_ready), 32'h1);
    repeat (4) cycle();
    clear_all();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bram_port_arbiter
